// File: rtl/fmv_pkg.sv
// Shared types for the FMV DDR path: master bundles, arbiter states.
package fmv_pkg;

  localparam int FMV_ADDR_W = 29;
  localparam int FMV_BURST_W = 8;
  localparam logic [3:0] DDR_CORE_BASE = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWNED,
    ST_DRAIN,
    ST_GAP
  } arb_state_e;

  typedef struct packed {
    logic                   acquire;
    logic                   read;
    logic                   write;
    logic [FMV_ADDR_W-1:0]  addr;
    logic [FMV_BURST_W-1:0] burstcnt;
    logic [63:0]            wdata;
    logic [7:0]             byteenable;
  } ddr_master_req_s;

  typedef struct packed {
    logic        busy;
    logic        rdata_ready;
    logic [63:0] rdata;
  } ddr_master_rsp_s;

endpackage

// File: rtl/ddr_beat_tracker.sv
// Outstanding read-beat counter with accept/return net update
// and a sticky flag for beats that arrive with nothing pending.
module ddr_beat_tracker #(
  parameter int BURST_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_accept,
  input  logic [BURST_W-1:0] i_burstcnt,
  input  logic               i_beat,
  output logic [BURST_W:0]   o_out_nxt,
  output logic               o_fits,
  output logic               o_beat_ok
);

  localparam int OW = BURST_W + 1;

  logic [OW-1:0] r_out;
  logic          r_err_stray;
  logic [OW:0]   w_sum;
  logic [OW-1:0] w_nxt;

  assign w_sum     = {1'b0, r_out} + {2'b0, i_burstcnt};
  assign o_fits    = !w_sum[OW];
  assign o_beat_ok = i_beat && (r_out != '0);
  assign o_out_nxt = w_nxt;

  always_comb begin
    w_nxt = r_out;
    if (i_accept) w_nxt = w_sum[OW-1:0];
    if (o_beat_ok) w_nxt = w_nxt - OW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out       <= '0;
      r_err_stray <= 1'b0;
    end else begin
      r_out <= w_nxt;
      if (i_beat && (r_out == '0)) r_err_stray <= 1'b1;
    end
  end

endmodule

// File: rtl/ddr_read_arbiter.sv
// Three-master DDR port arbiter for the FMV path: M0 priority with
// a starvation cap, round-robin M1/M2, beat routing to the owner.
module ddr_read_arbiter
  import fmv_pkg::*;
#(
  parameter int ADDR_W        = FMV_ADDR_W,
  parameter int BURST_W       = FMV_BURST_W,
  parameter int M0_MAX_CONSEC = 4
) (
  input  logic               clkddr,
  input  logic               reset,
  input  logic               m0_acquire,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [ADDR_W-1:0]  m0_addr,
  input  logic [BURST_W-1:0] m0_burstcnt,
  input  logic [63:0]        m0_wdata,
  input  logic [7:0]         m0_byteenable,
  output logic               m0_busy,
  output logic               m0_rdata_ready,
  output logic [63:0]        m0_rdata,
  output logic               m0_grant,
  input  logic               m1_acquire,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [ADDR_W-1:0]  m1_addr,
  input  logic [BURST_W-1:0] m1_burstcnt,
  input  logic [63:0]        m1_wdata,
  input  logic [7:0]         m1_byteenable,
  output logic               m1_busy,
  output logic               m1_rdata_ready,
  output logic [63:0]        m1_rdata,
  output logic               m1_grant,
  input  logic               m2_acquire,
  input  logic               m2_read,
  input  logic               m2_write,
  input  logic [ADDR_W-1:0]  m2_addr,
  input  logic [BURST_W-1:0] m2_burstcnt,
  input  logic [63:0]        m2_wdata,
  input  logic [7:0]         m2_byteenable,
  output logic               m2_busy,
  output logic               m2_rdata_ready,
  output logic [63:0]        m2_rdata,
  output logic               m2_grant,
  output logic               ddr_acquire,
  output logic               ddr_read,
  output logic               ddr_write,
  output logic [ADDR_W-1:0]  ddr_addr,
  output logic [BURST_W-1:0] ddr_burstcnt,
  output logic [63:0]        ddr_wdata,
  output logic [7:0]         ddr_byteenable,
  input  logic               ddr_busy,
  input  logic               ddr_rdata_ready,
  input  logic [63:0]        ddr_rdata
);

  localparam int CW = $clog2(M0_MAX_CONSEC + 1);
  localparam logic [CW-1:0] MAXC = CW'(M0_MAX_CONSEC);

  ddr_master_req_s w_req [3];
  ddr_master_rsp_s w_rsp [3];
  ddr_master_req_s w_own;

  arb_state_e    r_state, w_state_nxt;
  logic [2:0]    r_grant, w_grant_nxt;
  logic [CW-1:0] r_consec, w_consec_nxt;
  logic          r_rr_m2, w_rr_nxt;

  logic [2:0]    w_acq;
  logic          w_owned;
  logic          w_fits;
  logic          w_beat_ok;
  logic          w_accept;
  logic          w_own_busy;
  logic          w_m0_wins;
  logic          w_pick_m2;
  logic [BURST_W:0] w_out_nxt;

  assign w_req[0] = '{m0_acquire, m0_read, m0_write, m0_addr,
                      m0_burstcnt, m0_wdata, m0_byteenable};
  assign w_req[1] = '{m1_acquire, m1_read, m1_write, m1_addr,
                      m1_burstcnt, m1_wdata, m1_byteenable};
  assign w_req[2] = '{m2_acquire, m2_read, m2_write, m2_addr,
                      m2_burstcnt, m2_wdata, m2_byteenable};

  assign w_acq = {w_req[2].acquire, w_req[1].acquire, w_req[0].acquire};

  always_comb begin
    w_own = '0;
    unique case (1'b1)
      r_grant[0]: w_own = w_req[0];
      r_grant[1]: w_own = w_req[1];
      r_grant[2]: w_own = w_req[2];
      default:    w_own = '0;
    endcase
  end

  assign w_owned = (r_state == ST_OWNED);

  // Reads that would overflow the beat counter are held off here.
  assign ddr_acquire    = w_owned;
  assign ddr_read       = w_owned && w_own.read && w_fits;
  assign ddr_write      = w_owned && w_own.write;
  assign ddr_addr       = w_owned ? w_own.addr : '0;
  assign ddr_burstcnt   = w_owned ? w_own.burstcnt : '0;
  assign ddr_wdata      = w_owned ? w_own.wdata : '0;
  assign ddr_byteenable = w_owned ? w_own.byteenable : '0;

  assign w_own_busy = ddr_busy || (w_own.read && !w_fits);
  assign w_accept   = ddr_read && !ddr_busy;

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      w_rsp[n].busy        = !(w_owned && r_grant[n]) || w_own_busy;
      w_rsp[n].rdata_ready = w_beat_ok && r_grant[n];
      w_rsp[n].rdata       = ddr_rdata;
    end
  end

  assign m0_busy        = w_rsp[0].busy;
  assign m0_rdata_ready = w_rsp[0].rdata_ready;
  assign m0_rdata       = w_rsp[0].rdata;
  assign m1_busy        = w_rsp[1].busy;
  assign m1_rdata_ready = w_rsp[1].rdata_ready;
  assign m1_rdata       = w_rsp[1].rdata;
  assign m2_busy        = w_rsp[2].busy;
  assign m2_rdata_ready = w_rsp[2].rdata_ready;
  assign m2_rdata       = w_rsp[2].rdata;
  assign m0_grant       = r_grant[0];
  assign m1_grant       = r_grant[1];
  assign m2_grant       = r_grant[2];

  ddr_beat_tracker #(
    .BURST_W (BURST_W)
  ) u_trk (
    .i_clk      (clkddr),
    .i_rst_n    (reset),
    .i_accept   (w_accept),
    .i_burstcnt (w_own.burstcnt),
    .i_beat     (ddr_rdata_ready),
    .o_out_nxt  (w_out_nxt),
    .o_fits     (w_fits),
    .o_beat_ok  (w_beat_ok)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_consec_nxt = r_consec;
    w_rr_nxt     = r_rr_m2;
    w_m0_wins    = w_acq[0] &&
                   ((r_consec < MAXC) || !(w_acq[1] || w_acq[2]));
    w_pick_m2    = r_rr_m2 ? w_acq[2] : !w_acq[1];
    unique case (r_state)
      ST_IDLE: begin
        if (|w_acq) begin
          w_state_nxt = ST_OWNED;
          if (w_m0_wins) begin
            w_grant_nxt = 3'b001;
            if (r_consec != MAXC) w_consec_nxt = r_consec + 1'b1;
          end else begin
            w_consec_nxt = '0;
            w_grant_nxt  = w_pick_m2 ? 3'b100 : 3'b010;
            w_rr_nxt     = !w_pick_m2;
          end
        end
      end
      ST_OWNED: begin
        if (!w_own.acquire) begin
          if (w_out_nxt == '0) begin
            w_state_nxt = ST_GAP;
            w_grant_nxt = '0;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_out_nxt == '0) begin
          w_state_nxt = ST_GAP;
          w_grant_nxt = '0;
        end
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkddr) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_consec <= '0;
      r_rr_m2  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_consec <= w_consec_nxt;
      r_rr_m2  <= w_rr_nxt;
    end
  end

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Directed bench for ddr_read_arbiter: vector table for the owned
// command path plus sequences for arbitration, drain, reset, strays.
module tb_ddr_read_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        m0_acquire, m0_read, m0_write;
  logic [28:0] m0_addr;
  logic [7:0]  m0_burstcnt, m0_byteenable;
  logic [63:0] m0_wdata, m0_rdata;
  logic        m0_busy, m0_rdata_ready, m0_grant;
  logic        m1_acquire, m1_read, m1_write;
  logic [28:0] m1_addr;
  logic [7:0]  m1_burstcnt, m1_byteenable;
  logic [63:0] m1_wdata, m1_rdata;
  logic        m1_busy, m1_rdata_ready, m1_grant;
  logic        m2_acquire, m2_read, m2_write;
  logic [28:0] m2_addr;
  logic [7:0]  m2_burstcnt, m2_byteenable;
  logic [63:0] m2_wdata, m2_rdata;
  logic        m2_busy, m2_rdata_ready, m2_grant;
  logic        ddr_acquire, ddr_read, ddr_write;
  logic [28:0] ddr_addr;
  logic [7:0]  ddr_burstcnt, ddr_byteenable;
  logic [63:0] ddr_wdata, ddr_rdata;
  logic        ddr_busy, ddr_rdata_ready;

  ddr_read_arbiter dut (
    .clkddr(clk), .reset(reset),
    .m0_acquire(m0_acquire), .m0_read(m0_read), .m0_write(m0_write),
    .m0_addr(m0_addr), .m0_burstcnt(m0_burstcnt), .m0_wdata(m0_wdata),
    .m0_byteenable(m0_byteenable), .m0_busy(m0_busy),
    .m0_rdata_ready(m0_rdata_ready), .m0_rdata(m0_rdata),
    .m0_grant(m0_grant),
    .m1_acquire(m1_acquire), .m1_read(m1_read), .m1_write(m1_write),
    .m1_addr(m1_addr), .m1_burstcnt(m1_burstcnt), .m1_wdata(m1_wdata),
    .m1_byteenable(m1_byteenable), .m1_busy(m1_busy),
    .m1_rdata_ready(m1_rdata_ready), .m1_rdata(m1_rdata),
    .m1_grant(m1_grant),
    .m2_acquire(m2_acquire), .m2_read(m2_read), .m2_write(m2_write),
    .m2_addr(m2_addr), .m2_burstcnt(m2_burstcnt), .m2_wdata(m2_wdata),
    .m2_byteenable(m2_byteenable), .m2_busy(m2_busy),
    .m2_rdata_ready(m2_rdata_ready), .m2_rdata(m2_rdata),
    .m2_grant(m2_grant),
    .ddr_acquire(ddr_acquire), .ddr_read(ddr_read),
    .ddr_write(ddr_write), .ddr_addr(ddr_addr),
    .ddr_burstcnt(ddr_burstcnt), .ddr_wdata(ddr_wdata),
    .ddr_byteenable(ddr_byteenable), .ddr_busy(ddr_busy),
    .ddr_rdata_ready(ddr_rdata_ready), .ddr_rdata(ddr_rdata)
  );

  typedef struct {
    logic       rd, wr, m0rd, busy, beat;
    logic [7:0] bc;
    logic       e_rd, e_wr, e_b1, e_b0, e_rdy;
    int         e_out;
  } vec_t;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  vec_t tv [11];
  int   exp_seq [15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1};
  int   seq [$];
  int   total = 0;
  int   bad = 0;
  int   cnt;
  logic [2:0] g, prev;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    {m0_acquire, m0_read, m0_write} = '0;
    {m1_acquire, m1_read, m1_write} = '0;
    {m2_acquire, m2_read, m2_write} = '0;
    ddr_busy = 1'b0;
    ddr_rdata_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] outst();
    return 32'(dut.u_trk.r_out);
  endfunction

  initial begin
    tv[0]  = '{T, F, F, T, F, 8'd4,   T, F, T, T, F, 0};
    tv[1]  = '{T, F, F, F, F, 8'd4,   T, F, F, T, F, 4};
    tv[2]  = '{F, F, F, F, T, 8'd4,   F, F, F, T, T, 3};
    tv[3]  = '{T, F, F, F, T, 8'd10,  T, F, F, T, T, 12};
    tv[4]  = '{F, T, F, F, F, 8'd10,  F, T, F, T, F, 12};
    tv[5]  = '{F, F, T, F, F, 8'd10,  F, F, F, T, F, 12};
    tv[6]  = '{T, F, F, F, F, 8'd255, T, F, F, T, F, 267};
    tv[7]  = '{T, F, F, F, F, 8'd255, F, F, T, T, F, 267};
    tv[8]  = '{T, F, F, F, F, 8'd244, T, F, F, T, F, 511};
    tv[9]  = '{T, F, F, F, F, 8'd1,   F, F, T, T, F, 511};
    tv[10] = '{T, F, F, F, T, 8'd1,   F, F, T, T, T, 510};

    m0_addr = 29'h1234567; m0_burstcnt = 8'd0;
    m0_wdata = 64'h0; m0_byteenable = 8'h0;
    m1_addr = 29'h0ABCDEF; m1_burstcnt = 8'd0;
    m1_wdata = 64'hCAFE_F00D_1234_5678; m1_byteenable = 8'h5A;
    m2_addr = 29'h1555000; m2_burstcnt = 8'd0;
    m2_wdata = 64'h0; m2_byteenable = 8'h0;
    ddr_rdata = 64'h0;
    do_reset();
    tick();

    @(negedge clk);
    chk("rst grants", 32'({m2_grant, m1_grant, m0_grant}), 0);
    chk("rst busy", 32'({m2_busy, m1_busy, m0_busy}), 7);
    chk("rst ddr cmd", 32'({ddr_acquire, ddr_read, ddr_write}), 0);
    chk("rst rdy", 32'({m2_rdata_ready, m1_rdata_ready, m0_rdata_ready}), 0);
    chk("rst outst", outst(), 0);
    chk("rst stray", 32'(dut.u_trk.r_err_stray), 0);
    tick();

    // lone M0 burst of 21
    m0_acquire = 1'b1;
    @(negedge clk);
    chk("m0 grant pre", 32'(m0_grant), 0);
    tick();
    chk("m0 grant +1", 32'(m0_grant), 1);
    m0_read = 1'b1;
    m0_burstcnt = 8'd21;
    @(negedge clk);
    chk("m0 ddr_acq", 32'(ddr_acquire), 1);
    chk("m0 ddr_addr", 32'(ddr_addr), 32'h1234567);
    chk("m0 ddr_bc", 32'(ddr_burstcnt), 21);
    chk("m0 busy", 32'(m0_busy), 0);
    chk("m1 busy nonowner", 32'(m1_busy), 1);
    tick();
    m0_read = 1'b0;
    chk("m0 outst", outst(), 21);
    cnt = 0;
    for (int i = 0; i < 21; i++) begin
      ddr_rdata_ready = 1'b1;
      ddr_rdata = 64'hBEEF_0000 + 64'(i);
      @(negedge clk);
      if (m0_rdata_ready && !m1_rdata_ready && !m2_rdata_ready &&
          m0_rdata == ddr_rdata) cnt++;
      tick();
    end
    ddr_rdata_ready = 1'b0;
    chk("m0 beats", 32'(cnt), 21);
    chk("m0 outst end", outst(), 0);
    m0_acquire = 1'b0;
    m1_acquire = 1'b1;
    tick();
    chk("gap grants", 32'({m2_grant, m1_grant, m0_grant}), 0);
    tick();
    chk("idle m1 grant", 32'(m1_grant), 0);
    tick();
    chk("m1 grant turn", 32'(m1_grant), 1);

    // owned command path, M1 owner
    @(negedge clk);
    chk("m1 ddr_addr", 32'(ddr_addr), 32'h0ABCDEF);
    tick();
    for (int i = 0; i < 11; i++) begin
      m1_read = tv[i].rd;
      m1_write = tv[i].wr;
      m0_read = tv[i].m0rd;
      ddr_busy = tv[i].busy;
      ddr_rdata_ready = tv[i].beat;
      m1_burstcnt = tv[i].bc;
      @(negedge clk);
      chk($sformatf("v%0d ddr_read", i), 32'(ddr_read), 32'(tv[i].e_rd));
      chk($sformatf("v%0d ddr_write", i), 32'(ddr_write), 32'(tv[i].e_wr));
      chk($sformatf("v%0d m1_busy", i), 32'(m1_busy), 32'(tv[i].e_b1));
      chk($sformatf("v%0d m0_busy", i), 32'(m0_busy), 32'(tv[i].e_b0));
      chk($sformatf("v%0d m1_rdy", i), 32'(m1_rdata_ready),
          32'(tv[i].e_rdy));
      if (tv[i].wr) begin
        chk("wr wdata", ddr_wdata[31:0], 32'h1234_5678);
        chk("wr be", 32'(ddr_byteenable), 32'h5A);
      end
      tick();
      chk($sformatf("v%0d outst", i), outst(), 32'(tv[i].e_out));
    end
    m1_read = 1'b0; m1_write = 1'b0; m0_read = 1'b0;
    ddr_rdata_ready = 1'b0;

    // reset while owned with beats pending
    chk("pre-rst outst", outst(), 510);
    do_reset();
    chk("mid rst grants", 32'({m2_grant, m1_grant, m0_grant}), 0);
    chk("mid rst ddr_acq", 32'(ddr_acquire), 0);
    chk("mid rst outst", outst(), 0);
    chk("mid rst busy", 32'({m2_busy, m1_busy, m0_busy}), 7);

    // M2 drops acquire mid-burst, M1 waits for drain + gap
    m2_acquire = 1'b1;
    tick();
    chk("m2 grant", 32'(m2_grant), 1);
    m1_acquire = 1'b1;
    m2_read = 1'b1;
    m2_burstcnt = 8'd8;
    tick();
    m2_read = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      ddr_rdata_ready = 1'b1;
      @(negedge clk);
      if (m2_rdata_ready && !m1_rdata_ready) cnt++;
      tick();
    end
    ddr_rdata_ready = 1'b0;
    m2_acquire = 1'b0;
    tick();
    chk("drain outst", outst(), 5);
    chk("drain ddr_acq", 32'(ddr_acquire), 0);
    for (int i = 0; i < 5; i++) begin
      ddr_rdata_ready = 1'b1;
      @(negedge clk);
      if (m2_rdata_ready && !m1_rdata_ready && !m1_grant &&
          !ddr_acquire && !ddr_read) cnt++;
      tick();
    end
    ddr_rdata_ready = 1'b0;
    chk("m2 beats", 32'(cnt), 8);
    chk("m2 outst end", outst(), 0);
    chk("m1 wait gap", 32'(m1_grant), 0);
    tick();
    chk("m1 wait idle", 32'(m1_grant), 0);
    tick();
    chk("m1 grant drain", 32'(m1_grant), 1);

    // all three requesting continuously
    do_reset();
    prev = '0;
    for (int c = 0; c < 400 && seq.size() < 15; c++) begin
      @(negedge clk);
      g = {m2_grant, m1_grant, m0_grant};
      if (g != '0 && prev == '0)
        seq.push_back(g == 3'b001 ? 0 : g == 3'b010 ? 1 :
                      g == 3'b100 ? 2 : 9);
      prev = g;
      m0_acquire = !g[0];
      m1_acquire = !g[1];
      m2_acquire = !g[2];
    end
    chk("grant count", 32'(seq.size()), 15);
    for (int i = 0; i < seq.size(); i++)
      chk($sformatf("grant seq %0d", i), 32'(seq[i]), 32'(exp_seq[i]));

    // stray beat in IDLE
    tick();
    do_reset();
    tick();
    ddr_rdata_ready = 1'b1;
    @(negedge clk);
    chk("stray rdy", 32'({m2_rdata_ready, m1_rdata_ready, m0_rdata_ready}),
        0);
    tick();
    ddr_rdata_ready = 1'b0;
    chk("stray flag", 32'(dut.u_trk.r_err_stray), 1);
    chk("stray outst", outst(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
